// File: rtl/icache_linefill_ctrl.sv
// icache_linefill_ctrl
// Gathers BEAT_NUM downstream data beats for one MSHR entry into a line
// buffer. It then issues a single full-line data RAM write to the way/index
// that the MSHR file reports, and retires the entry with a one-cycle
// linefill_done pulse. Only one line is in flight at a time.
//
// Optional build macro: ICACHE_LINEFILL_BEAT_CHECK_EN
//   When it is defined, the block checks the txnid and rxdat_last of every
//   beat and raises a sticky linefill_err on a mismatch. When it is not
//   defined, linefill_err is tied to 0 and rxdat_last is ignored.
module icache_linefill_ctrl #(
    parameter int MSHR_ENTRY_NUM         = 8,
    parameter int MSHR_ENTRY_INDEX_WIDTH = 3,
    parameter int ICACHE_INDEX_WIDTH     = 7,
    parameter int BEAT_WIDTH             = 256,
    parameter int BEAT_NUM               = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rxdat_vld,
    output logic                              rxdat_rdy,
    input  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] rxdat_txnid,
    input  logic [BEAT_WIDTH-1:0]             rxdat_data,
    input  logic                              rxdat_last,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] lkp_entry_idx,
    input  logic                              lkp_way,
    input  logic [ICACHE_INDEX_WIDTH-1:0]     lkp_index,
    output logic                              dataram_wr_vld,
    input  logic                              dataram_wr_rdy,
    output logic                              dataram_wr_way,
    output logic [ICACHE_INDEX_WIDTH-1:0]     dataram_wr_index,
    output logic [BEAT_WIDTH*BEAT_NUM-1:0]    dataram_wr_data,
    output logic                              linefill_done,
    output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] linefill_ack_index,
    output logic                              busy,
    output logic                              linefill_err
);

    localparam int CNT_W = $clog2(BEAT_NUM + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] txnid_q, txnid_d;
    logic                              way_q, way_d;
    logic [ICACHE_INDEX_WIDTH-1:0]     index_q, index_d;

    logic                              beat_acc;
    logic                              final_beat;
    logic [CNT_W-1:0]                  wr_slot;

    // Line buffer, one slot per beat; it holds no state that matters across resets
    logic [BEAT_WIDTH-1:0]             line_mem [BEAT_NUM];

    // Next-state, beat acceptance and handshake outputs
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        txnid_d        = txnid_q;
        way_d          = way_q;
        index_d        = index_q;
        rxdat_rdy      = 1'b0;
        dataram_wr_vld = 1'b0;
        linefill_done  = 1'b0;
        lkp_entry_idx  = txnid_q;
        wr_slot        = cnt_q;
        beat_acc       = 1'b0;
        final_beat     = 1'b0;

        case (state_q)
            S_IDLE: begin
                rxdat_rdy     = 1'b1;
                // When the line has one beat, the lookup has to see the incoming txnid
                lkp_entry_idx = rxdat_txnid;
                wr_slot       = '0;
                if (rxdat_vld) begin
                    beat_acc = 1'b1;
                    txnid_d  = rxdat_txnid;
                    cnt_d    = CNT_W'(1);
                    if (BEAT_NUM == 1) begin
                        final_beat = 1'b1;
                        state_d    = S_WRITE;
                    end else begin
                        state_d    = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                rxdat_rdy = 1'b1;
                if (rxdat_vld) begin
                    beat_acc = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        final_beat = 1'b1;
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                dataram_wr_vld = 1'b1;
                if (dataram_wr_rdy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                linefill_done = 1'b1;
                cnt_d         = '0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture the target location together with the final beat so it stays fixed while writing
        if (final_beat) begin
            way_d   = lkp_way;
            index_d = lkp_index;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            txnid_q <= '0;
            way_q   <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txnid_q <= txnid_d;
            way_q   <= way_d;
            index_q <= index_d;
        end
    end

    // Line buffer write: each accepted beat goes into the slot the counter selects
    always_ff @(posedge clk) begin
        for (int i = 0; i < BEAT_NUM; i++) begin
            if (beat_acc && (wr_slot == CNT_W'(i))) begin
                line_mem[i] <= rxdat_data;
            end
        end
    end

    // Pack the slots into the write bus; it reads zero when no write is pending
    for (genvar gi = 0; gi < BEAT_NUM; gi++) begin : g_pack
        assign dataram_wr_data[gi*BEAT_WIDTH +: BEAT_WIDTH] =
            dataram_wr_vld ? line_mem[gi] : '0;
    end

    assign dataram_wr_way     = way_q;
    assign dataram_wr_index   = index_q;
    assign linefill_ack_index = linefill_done ? txnid_q : '0;
    assign busy               = (state_q != S_IDLE);

`ifdef ICACHE_LINEFILL_BEAT_CHECK_EN
    logic err_q, err_d;

    // Beat protocol check: each later beat must repeat the captured txnid, and last must mark the final slot
    always_comb begin
        err_d = err_q;
        if (beat_acc) begin
            if ((state_q == S_COLLECT) && (rxdat_txnid != txnid_q)) begin
                err_d = 1'b1;
            end
            if (rxdat_last != (wr_slot == LAST_CNT)) begin
                err_d = 1'b1;
            end
        end
    end

    // Sticky error flag; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign linefill_err = err_q;
`else
    logic unused_last;
    assign unused_last  = rxdat_last;
    assign linefill_err = 1'b0;
`endif

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed testbench for icache_linefill_ctrl. It uses a BEAT_NUM=2
// instance for most scenarios and a BEAT_NUM=1 instance for the single-beat
// case.
module tb_icache_linefill_ctrl;

    localparam int IW = 3;
    localparam int XW = 7;
    localparam int BW = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;

    // ---------------- BEAT_NUM = 2 instance ----------------
    logic           vld, rdy, last;
    logic [IW-1:0]  txnid, lkp_idx;
    logic [BW-1:0]  data;
    logic           way_drv, mshr_model;
    logic [XW-1:0]  index_drv;
    logic           lkp_way;
    logic [XW-1:0]  lkp_index;
    logic           wr_vld, wr_rdy, wr_way;
    logic [XW-1:0]  wr_index;
    logic [2*BW-1:0] wr_data;
    logic           done, busy, err;
    logic [IW-1:0]  ack;

    // Simple MSHR lookup stand-in: the way is the low txnid bit and the index is 0x40|txnid
    assign lkp_way   = mshr_model ? lkp_idx[0] : way_drv;
    assign lkp_index = mshr_model ? (7'h40 | {4'h0, lkp_idx}) : index_drv;

    icache_linefill_ctrl #(
        .MSHR_ENTRY_NUM(8), .MSHR_ENTRY_INDEX_WIDTH(IW), .ICACHE_INDEX_WIDTH(XW),
        .BEAT_WIDTH(BW), .BEAT_NUM(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rxdat_vld(vld), .rxdat_rdy(rdy), .rxdat_txnid(txnid),
        .rxdat_data(data), .rxdat_last(last),
        .lkp_entry_idx(lkp_idx), .lkp_way(lkp_way), .lkp_index(lkp_index),
        .dataram_wr_vld(wr_vld), .dataram_wr_rdy(wr_rdy), .dataram_wr_way(wr_way),
        .dataram_wr_index(wr_index), .dataram_wr_data(wr_data),
        .linefill_done(done), .linefill_ack_index(ack),
        .busy(busy), .linefill_err(err)
    );

    // ---------------- BEAT_NUM = 1 instance ----------------
    logic           vld1, rdy1, last1;
    logic [IW-1:0]  txnid1, lkp_idx1;
    logic [BW-1:0]  data1;
    logic           lkp_way1;
    logic [XW-1:0]  lkp_index1;
    logic           wr_vld1, wr_rdy1, wr_way1;
    logic [XW-1:0]  wr_index1;
    logic [BW-1:0]  wr_data1;
    logic           done1, busy1, err1;
    logic [IW-1:0]  ack1;

    icache_linefill_ctrl #(
        .MSHR_ENTRY_NUM(8), .MSHR_ENTRY_INDEX_WIDTH(IW), .ICACHE_INDEX_WIDTH(XW),
        .BEAT_WIDTH(BW), .BEAT_NUM(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rxdat_vld(vld1), .rxdat_rdy(rdy1), .rxdat_txnid(txnid1),
        .rxdat_data(data1), .rxdat_last(last1),
        .lkp_entry_idx(lkp_idx1), .lkp_way(lkp_way1), .lkp_index(lkp_index1),
        .dataram_wr_vld(wr_vld1), .dataram_wr_rdy(wr_rdy1), .dataram_wr_way(wr_way1),
        .dataram_wr_index(wr_index1), .dataram_wr_data(wr_data1),
        .linefill_done(done1), .linefill_ack_index(ack1),
        .busy(busy1), .linefill_err(err1)
    );

    // Stimulus: present one beat and hold it until it is accepted (bounded wait).
    // The task returns 1 ns after the accepting edge.
    task automatic drive_beat(input logic [IW-1:0] id, input logic [BW-1:0] d, input logic lst);
        int n = 0;
        vld = 1'b1; txnid = id; data = d; last = lst;
        @(negedge clk);
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL beat_accept: rxdat_rdy=%b after %0d cycles, required 1", rdy, n);
        end
        @(posedge clk); #1;
        vld = 1'b0;
        $display("beat txnid=%0d last=%b data[31:0]=%h", id, lst, d[31:0]);
    endtask

    task automatic test_reset;
        #2;
        asserts++;
        if ({rdy, busy, wr_vld, done, ack, err, wr_way, wr_index} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 7'd0}) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b busy=%b wr_vld=%b done=%b ack=%0d err=%b way=%b idx=%h, required rdy=1 others 0",
                     rdy, busy, wr_vld, done, ack, err, wr_way, wr_index);
        end
        asserts++;
        if (wr_data !== '0) begin
            fails++;
            $display("FAIL reset_wr_data: got nonzero, required 0");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic;
        logic [BW-1:0] da = {8{32'hA0A0_0001}};
        logic [BW-1:0] db = {8{32'hB0B0_0002}};
        mshr_model = 1'b0; way_drv = 1'b1; index_drv = 7'h2A; wr_rdy = 1'b1;
        drive_beat(3'd3, da, 1'b0);
        asserts++;
        if (busy !== 1'b1 || lkp_idx !== 3'd3) begin
            fails++;
            $display("FAIL basic_collect: busy=%b lkp_idx=%0d, required busy=1 lkp_idx=3", busy, lkp_idx);
        end
        drive_beat(3'd3, db, 1'b1);
        // Drop the lookup inputs so the bench can see that way/index were registered
        way_drv = 1'b0; index_drv = 7'h00;
        @(negedge clk);
        asserts++;
        if (wr_vld !== 1'b1 || wr_way !== 1'b1 || wr_index !== 7'h2A || rdy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL basic_write: wr_vld=%b way=%b idx=%h rdy=%b done=%b, required 1 1 2a 0 0",
                     wr_vld, wr_way, wr_index, rdy, done);
        end
        asserts++;
        if (wr_data !== {db, da}) begin
            fails++;
            $display("FAIL basic_wr_data: got %h..%h, required %h..%h",
                     wr_data[511:480], wr_data[31:0], db[31:0], da[31:0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        asserts++;
        if (done !== 1'b1 || ack !== 3'd3 || wr_vld !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: done=%b ack=%0d wr_vld=%b, required 1 3 0", done, ack, wr_vld);
        end
        @(posedge clk); #1;
        @(negedge clk);
        asserts++;
        if (done !== 1'b0 || ack !== 3'd0 || rdy !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle: done=%b ack=%0d rdy=%b busy=%b, required 0 0 1 0", done, ack, rdy, busy);
        end
        @(posedge clk); #1;
        $display("line txnid=3 written way=1 index=2a");
    endtask

    task automatic test_stall;
        logic [BW-1:0] dc = {8{32'hC0C0_0003}};
        logic [BW-1:0] dd = {8{32'hD0D0_0004}};
        int done_cnt = 0;
        mshr_model = 1'b0; way_drv = 1'b0; index_drv = 7'h55; wr_rdy = 1'b0;
        drive_beat(3'd3, dc, 1'b0);
        drive_beat(3'd3, dd, 1'b1);
        way_drv = 1'b1; index_drv = 7'h00;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) wr_rdy = 1'b1;
            @(negedge clk);
            asserts++;
            if (wr_vld !== 1'b1 || wr_way !== 1'b0 || wr_index !== 7'h55 || wr_data !== {dd, dc} || rdy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: wr_vld=%b way=%b idx=%h rdy=%b done=%b data_ok=%b, required 1 0 55 0 0 1",
                         i, wr_vld, wr_way, wr_index, rdy, done, wr_data === {dd, dc});
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (i == 0) begin
                asserts++;
                if (done !== 1'b1 || ack !== 3'd3) begin
                    fails++;
                    $display("FAIL stall_done: done=%b ack=%0d, required 1 3", done, ack);
                end
            end
            @(posedge clk); #1;
        end
        asserts++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL stall_done_count: %0d pulses, required 1", done_cnt);
        end
        $display("line txnid=3 written after 5 stall cycles");
    endtask

    task automatic test_back_to_back;
        logic [BW-1:0] de = {8{32'hE0E0_0005}};
        logic [BW-1:0] df = {8{32'hF0F0_0006}};
        logic [BW-1:0] dg = {8{32'h1111_0007}};
        logic [BW-1:0] dh = {8{32'h2222_0008}};
        logic [BW-1:0] c_data [8];
        bit       c_vld  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        bit       c_last [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
        int       c_id   [8] = '{1, 1, 6, 6, 6, 6, 0, 0};
        bit       e_rdy  [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        bit       e_wv   [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        bit       e_done [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int       e_ack  [8] = '{0, 0, 0, 1, 0, 0, 0, 6};
        c_data = '{de, df, dg, dg, dg, dh, '0, '0};
        mshr_model = 1'b1; wr_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            vld = c_vld[c]; txnid = IW'(c_id[c]); data = c_data[c]; last = c_last[c];
            @(negedge clk);
            asserts++;
            if (rdy !== e_rdy[c] || wr_vld !== e_wv[c] || done !== e_done[c] || ack !== IW'(e_ack[c])) begin
                fails++;
                $display("FAIL b2b_cycle[%0d]: rdy=%b wr_vld=%b done=%b ack=%0d, required %b %b %b %0d",
                         c, rdy, wr_vld, done, ack, e_rdy[c], e_wv[c], e_done[c], e_ack[c]);
            end
            if (c == 2) begin
                asserts++;
                if (wr_way !== 1'b1 || wr_index !== 7'h41 || wr_data !== {df, de}) begin
                    fails++;
                    $display("FAIL b2b_line1: way=%b idx=%h data_ok=%b, required 1 41 1", wr_way, wr_index, wr_data === {df, de});
                end
            end
            if (c == 6) begin
                asserts++;
                if (wr_way !== 1'b0 || wr_index !== 7'h46 || wr_data !== {dh, dg}) begin
                    fails++;
                    $display("FAIL b2b_line2: way=%b idx=%h data_ok=%b, required 0 46 1", wr_way, wr_index, wr_data === {dh, dg});
                end
            end
            @(posedge clk); #1;
        end
        vld = 1'b0;
        $display("back-to-back lines txnid=1 then txnid=6 written");
    endtask

    task automatic test_reset_mid;
        logic [BW-1:0] dx = {8{32'h5555_0009}};
        logic [BW-1:0] di = {8{32'h3333_000A}};
        logic [BW-1:0] dj = {8{32'h4444_000B}};
        int done_cnt = 0;
        mshr_model = 1'b1; wr_rdy = 1'b1;
        drive_beat(3'd5, dx, 1'b0);
        rst_n = 1'b0;
        #1;
        asserts++;
        if (busy !== 1'b0 || rdy !== 1'b1 || wr_vld !== 1'b0 || done !== 1'b0 || ack !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: busy=%b rdy=%b wr_vld=%b done=%b ack=%0d, required 0 1 0 0 0",
                     busy, rdy, wr_vld, done, ack);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        asserts++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_no_done: done pulses=%0d busy=%b, required 0 0", done_cnt, busy);
        end
        @(posedge clk); #1;
        drive_beat(3'd2, di, 1'b0);
        drive_beat(3'd2, dj, 1'b1);
        @(negedge clk);
        asserts++;
        if (wr_vld !== 1'b1 || wr_way !== 1'b0 || wr_index !== 7'h42 || wr_data !== {dj, di}) begin
            fails++;
            $display("FAIL reset_mid_line: wr_vld=%b way=%b idx=%h data_ok=%b, required 1 0 42 1",
                     wr_vld, wr_way, wr_index, wr_data === {dj, di});
        end
        @(posedge clk); #1;
        @(negedge clk);
        asserts++;
        if (done !== 1'b1 || ack !== 3'd2) begin
            fails++;
            $display("FAIL reset_mid_done: done=%b ack=%0d, required 1 2", done, ack);
        end
        @(posedge clk); #1;
        $display("reset mid-line txnid=5 dropped, line txnid=2 written");
    endtask

    task automatic test_beat_check;
        logic [BW-1:0] dk0 = {8{32'h6666_000C}};
        logic [BW-1:0] dk1 = {8{32'h7777_000D}};
        logic exp_err;
`ifdef ICACHE_LINEFILL_BEAT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        mshr_model = 1'b0; way_drv = 1'b1; index_drv = 7'h33; wr_rdy = 1'b1;
        drive_beat(3'd2, dk0, 1'b0);
        asserts++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL check_beat0_err: err=%b, required 0", err);
        end
        drive_beat(3'd4, dk1, 1'b1);
        @(negedge clk);
        asserts++;
        if (err !== exp_err || wr_vld !== 1'b1 || wr_index !== 7'h33 || wr_data !== {dk1, dk0}) begin
            fails++;
            $display("FAIL check_write: err=%b wr_vld=%b idx=%h data_ok=%b, required err=%b 1 33 1",
                     err, wr_vld, wr_index, wr_data === {dk1, dk0}, exp_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        asserts++;
        if (done !== 1'b1 || ack !== 3'd2 || err !== exp_err) begin
            fails++;
            $display("FAIL check_done: done=%b ack=%0d err=%b, required 1 2 %b", done, ack, err, exp_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        asserts++;
        if (err !== exp_err || busy !== 1'b0) begin
            fails++;
            $display("FAIL check_sticky: err=%b busy=%b, required %b 0", err, busy, exp_err);
        end
        @(posedge clk); #1;
        $display("line txnid=2 with stray beat txnid=4 written, err=%b", err);
    endtask

    task automatic test_single_beat;
        logic [BW-1:0] dk = {8{32'h9999_000E}};
        vld1 = 1'b1; txnid1 = 3'd7; data1 = dk; last1 = 1'b1;
        lkp_way1 = 1'b1; lkp_index1 = 7'h7F; wr_rdy1 = 1'b1;
        @(negedge clk);
        asserts++;
        if (rdy1 !== 1'b1 || lkp_idx1 !== 3'd7) begin
            fails++;
            $display("FAIL single_idle: rdy=%b lkp_idx=%0d, required 1 7", rdy1, lkp_idx1);
        end
        @(posedge clk); #1;
        vld1 = 1'b0; lkp_way1 = 1'b0; lkp_index1 = 7'h00;
        @(negedge clk);
        asserts++;
        if (wr_vld1 !== 1'b1 || wr_way1 !== 1'b1 || wr_index1 !== 7'h7F || wr_data1 !== dk || rdy1 !== 1'b0) begin
            fails++;
            $display("FAIL single_write: wr_vld=%b way=%b idx=%h rdy=%b data_ok=%b, required 1 1 7f 0 1",
                     wr_vld1, wr_way1, wr_index1, rdy1, wr_data1 === dk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        asserts++;
        if (done1 !== 1'b1 || ack1 !== 3'd7) begin
            fails++;
            $display("FAIL single_done: done=%b ack=%0d, required 1 7", done1, ack1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        asserts++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b1 || err1 !== 1'b0) begin
            fails++;
            $display("FAIL single_idle_after: done=%b busy=%b rdy=%b err=%b, required 0 0 1 0", done1, busy1, rdy1, err1);
        end
        @(posedge clk); #1;
        $display("single-beat line txnid=7 written");
    endtask

    initial begin
        vld = 1'b0; txnid = '0; data = '0; last = 1'b0;
        way_drv = 1'b0; index_drv = '0; mshr_model = 1'b0; wr_rdy = 1'b0;
        vld1 = 1'b0; txnid1 = '0; data1 = '0; last1 = 1'b0;
        lkp_way1 = 1'b0; lkp_index1 = '0; wr_rdy1 = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_beat_check();
        test_single_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache_linefill_ctrl.md
Name: icache_linefill_ctrl

Overview:
Sequences refill of one icache line from the downstream response channel into the data RAM, then retires the owning MSHR entry. Collects BEAT_NUM data beats tagged with the MSHR entry index (txnid) into a line buffer. Looks up the target way/index from the MSHR file, issues one full-line data RAM write, then pulses linefill_done/linefill_ack_index toward the MSHR file. Sits between the downstream rx data channel, the MSHR file and the data RAM write port; one line in flight at a time.

Parameters:
MSHR_ENTRY_NUM, 8, number of MSHR entries
MSHR_ENTRY_INDEX_WIDTH, 3, log2(MSHR_ENTRY_NUM); width of txnid/ack index
ICACHE_INDEX_WIDTH, 7, data RAM set index width
BEAT_WIDTH, 256, bits per downstream data beat
BEAT_NUM, 2, beats per cache line (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rxdat_vld  in  1  downstream data beat valid
rxdat_rdy  out  1  beat accepted when vld&&rdy
rxdat_txnid  in  MSHR_ENTRY_INDEX_WIDTH  owning MSHR entry index
rxdat_data  in  BEAT_WIDTH  beat payload, beat 0 first
rxdat_last  in  1  final beat marker (checked only under macro)
lkp_entry_idx  out  MSHR_ENTRY_INDEX_WIDTH  MSHR entry being looked up
lkp_way  in  1  replacement way of that entry (combinational from MSHR file)
lkp_index  in  ICACHE_INDEX_WIDTH  set index of that entry
dataram_wr_vld  out  1  line write request
dataram_wr_rdy  in  1  data RAM accepts write
dataram_wr_way  out  1  write way
dataram_wr_index  out  ICACHE_INDEX_WIDTH  write set index
dataram_wr_data  out  BEAT_WIDTH*BEAT_NUM  full line, beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
linefill_done  out  1  one-cycle pulse: line written
linefill_ack_index  out  MSHR_ENTRY_INDEX_WIDTH  entry retired with linefill_done
busy  out  1  state != IDLE
linefill_err  out  1  sticky protocol error (macro only, else 0)

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low. Reset: state IDLE, beat counter 0, all outputs 0 except rxdat_rdy=1; line buffer not reset.
- FSM states IDLE, COLLECT, WRITE, DONE.
- IDLE: rxdat_rdy=1. Beat accept -> store in slot 0, capture txnid, cnt=1; if BEAT_NUM==1 -> WRITE else -> COLLECT.
- COLLECT: rxdat_rdy=1. Each accept stores into slot cnt, cnt++. Accept with cnt==BEAT_NUM-1 -> WRITE. Completion is by beat count only; rxdat_txnid ignored after beat 0.
- lkp_entry_idx = rxdat_txnid in IDLE, captured txnid otherwise. lkp_way/lkp_index sampled into registers on the accept cycle of the final beat.
- WRITE: rxdat_rdy=0; dataram_wr_vld=1 with way/index/data held stable until dataram_wr_rdy. Handshake -> DONE. No timeout.
- DONE: rxdat_rdy=0; linefill_done=1 and linefill_ack_index=captured txnid for exactly one cycle -> IDLE. linefill_ack_index=0 whenever linefill_done=0.
- Latency: final beat accepted cycle T; wr_vld at T+1; with wr_rdy=1 at T+1, linefill_done at T+2; next beat acceptable at T+3.
- Back-to-back lines: no overlap; rxdat_rdy low in WRITE/DONE applies backpressure.
- Reset mid-line: buffered beats discarded; no linefill_done emitted.
- Beat counter width clog2(BEAT_NUM+1); no wrap beyond BEAT_NUM.

Optional Feature:
ICACHE_LINEFILL_BEAT_CHECK_EN: when defined, in COLLECT a beat whose txnid != captured txnid, or rxdat_last mismatching (last!=(cnt==BEAT_NUM-1), also checked on beat 0), sets linefill_err sticky until reset. Offending beat is still accepted and counted. When undefined, linefill_err tied 0, no check logic, rxdat_last unused.

Test Plan:
- Reset, BEAT_NUM=2: beats txnid=3 data A,B; lkp_way=1, lkp_index=0x2A; wr_rdy=1 -> wr_vld one cycle, way=1, index=0x2A, data={B,A}; linefill_done one cycle later with ack_index=3.
- Same but wr_rdy=0 for 5 cycles -> wr_vld/way/index/data stable 6 cycles, rxdat_rdy=0 throughout, single done pulse after handshake.
- Two lines back-to-back (txnid 1 then 6), vld held high -> rxdat_rdy drops T+1..T+2, second line accepted T+3, acks 1 then 6 in order.
- rst_n asserted after beat 0 of txnid 5 -> outputs to reset values immediately, no linefill_done; next full line txnid 2 completes normally.
- Macro defined: beat 1 txnid 4 vs captured 2 -> linefill_err=1 and stays 1; line still written, ack_index=2. Macro undefined: linefill_err=0.
- BEAT_NUM=1 build: single beat txnid 7 -> WRITE next cycle, ack_index=7.
